mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Sequential unsigned shift-add multiplier controller that time-multiplexes one `Ripple_Carry_Adder_nbit` instance over N cycles to form a 2N-bit product. It sits beside the ALU as the multi-cycle MUL/MULHU unit. It trades latency for area instead of instantiating an N×N array multiplier. It accepts an operand pair through a ready/start handshake, sequences the adder with a bit counter and FSM, and presents a registered product with a one-cycle done pulse.

## Interface
- `N`, default 32: operand width; must be ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  request; accepted only on a cycle where `ready`=1.
- `A`  in  N  multiplicand; sampled on acceptance.
- `B`  in  N  multiplier; sampled on acceptance.
- `ready`  out  1  controller can accept `start` this cycle.
- `busy`  out  1  multiplication in progress (state RUN).
- `done`  out  1  one-cycle pulse: `P` updated with a new result.
- `P`  out  2N  product; holds the last result until the next `done`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when cnt = N-1 (after that cycle's step).
  - DONE → RUN on `start`; otherwise DONE → IDLE.
- Datapath registers:
  - `mcand` (N bits), loaded with `A`.
  - `acc_hi` (N bits) plus carry bit `c`.
  - `acc_lo` (N bits), loaded with `B`.
  - `cnt` (clog2(N) bits).
- On acceptance: `mcand`←A, `acc_lo`←B, `acc_hi`←0, `c`←0, `cnt`←0.
- Each RUN cycle:
  - Adder inputs: A = `acc_hi`; B = `acc_lo[0]` ? `mcand` : 0; Cin = 0. This yields sum S and carry Cout.
  - `{c, acc_hi, acc_lo}` ← `{Cout, S, acc_lo}` >> 1. Net effect: `acc_hi` ← `{Cout, S[N-1:1]}`, `acc_lo` ← `{S[0], acc_lo[N-1:1]}`.
  - `cnt` ← `cnt`+1.
- Entering DONE: `P` ← `{acc_hi, acc_lo}` (after the final shift), and `done`=1 for that cycle.
- `ready` = (state==IDLE) || (state==DONE). `busy` = (state==RUN).
- `start` while `busy`: ignored. No queuing, and operands are not resampled.
- `A`/`B` may change freely after acceptance.
- Arithmetic is unsigned only. The result is exact modulo 2^2N; no overflow is possible.
- Reset at any time, including mid-RUN:
  - State → IDLE.
  - `P` = 0, `done` = 0, `busy` = 0, `ready` = 1 in the cycle after `rst`.
  - `cnt` and all accumulator registers cleared.
  - The partial result is discarded.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `P`=0.
- Start accepted at edge t (state becomes RUN) → RUN occupies N cycles → `done`=1 and `P` valid in cycle t+N+1.
- Total latency from accepting edge to `done`: N+1 cycles (33 for N=32).
- Back-to-back: a `start` during the DONE cycle is accepted. The next `done` comes N+1 cycles later, giving one result every N+1 cycles.
- The adder is combinational within one RUN cycle. The critical path is the N-bit ripple through `Ripple_Carry_Adder_nbit` plus the mux.
- `done` is never asserted for two consecutive cycles.

## Configuration
- Macro: `MUL_SEQ_ZERO_SKIP_EN`.
- Defined:
  - On acceptance, if A==0 or B==0, go directly to DONE with `P`←0.
  - `done` comes one cycle after acceptance, and RUN is never entered.
  - Nonzero operands behave as in the undefined case.
- Undefined: every operation takes the full N+1-cycle latency, regardless of operand values.

## Structure
- Shared package `mul_seq_pkg`:
  - State encoding localparams `S_IDLE`=2'd0, `S_RUN`=2'd1, `S_DONE`=2'd2.
  - Counter-width helper function (clog2).
- One sub-module: `Ripple_Carry_Adder_nbit #(N)`, instantiated once with Cin tied to 0.
- FSM, counter, shifter and output register live in `mul_seq_ctrl`.

## Test plan
- Basic: A=3, B=5, start at cycle 0 → `done` at cycle 33, `P`=0x0000_0000_0000_000F; `busy` high for cycles 1–32.
- Maximum: A=B=0xFFFF_FFFF → `P`=0xFFFF_FFFE_0000_0001; `Cout` path exercised.
- Busy rejection: start A=7, B=9, then pulse `start` with A=2, B=2 at cycle 10 → single `done` at 33, `P`=63, `ready`=0 for cycles 1–32.
- Reset mid-op: start A=0x1234, B=0x5678, assert `rst` at cycle 15 → `P`=0, `done`=0, `ready`=1 afterwards; a new start of A=6, B=7 gives `P`=42 after 33 cycles.
- Back-to-back: start A=10, B=10, then `start` during the DONE cycle with A=0x8000_0000, B=2 → `P`=100, then `P`=0x1_0000_0000 exactly 33 cycles later.
- Zero skip: A=0, B=0xDEAD with the macro defined → `done` one cycle after acceptance and `P`=0. With the macro undefined → `done` after 33 cycles and `P`=0.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the bit-counter width helper.
package mul_seq_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } state_e;

   // Ceiling log2, never below 1 so the counter always has at least one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mul_seq_ctrl_adder.sv
// N-bit ripple-carry adder built from a chain of full-adder cells; purely
// combinational, shared by the multiplier for one partial-product add per cycle.
module Ripple_Carry_Adder_nbit #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] S,
   output logic         Cout
);

   logic [N:0] carry;

   assign carry[0] = Cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign S[i]         = A[i] ^ B[i] ^ carry[i];
      assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
   end

   assign Cout = carry[N];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle unsigned shift-add multiplier: one shared ripple adder, N RUN
// cycles per product. Define MUL_SEQ_ZERO_SKIP_EN to short-cut zero operands.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   P
);

   localparam int unsigned    CW       = cnt_width(N);
   localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N-1:0]       mcand_q, mcand_d;
   logic [N-1:0]       acc_hi_q, acc_hi_d;
   logic [N-1:0]       acc_lo_q, acc_lo_d;
   logic [2*N-1:0]     p_q, p_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;

   logic [N-1:0]       add_b;
   logic [N-1:0]       add_s;
   logic               add_cout;
   logic               skip_c;

   assign add_b = acc_lo_q[0] ? mcand_q : '0;

   Ripple_Carry_Adder_nbit #(.N(N)) u_adder (
      .A    (acc_hi_q),
      .B    (add_b),
      .Cin  (1'b0),
      .S    (add_s),
      .Cout (add_cout)
   );

   // Zero-operand short cut applies only from IDLE so done can never repeat
   // on back-to-back cycles.
`ifdef MUL_SEQ_ZERO_SKIP_EN
   assign skip_c = (state_q == ST_IDLE) && ((A == '0) || (B == '0));
`else
   assign skip_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         p_q      <= '0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         p_q      <= p_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      p_d      = p_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
            if (start) begin
               mcand_d  = A;
               acc_lo_d = B;
               acc_hi_d = '0;
               cnt_d    = '0;
               if (skip_c) begin
                  state_d = ST_DONE;
                  p_d     = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // Add-then-shift: carry-out drops into the top of acc_hi, S[0] into acc_lo.
            acc_hi_d = {add_cout, add_s[N-1:1]};
            acc_lo_d = {add_s[0], acc_lo_q[N-1:1]};
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               p_d     = {add_cout, add_s, acc_lo_q[N-1:1]};
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
      busy_d  = (state_d == ST_RUN);
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign P     = p_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: issued operations push the expected
// product and done cycle; a negedge monitor checks handshake and result.
module tb_mul_seq_ctrl;

   localparam int unsigned N = 32;

   typedef struct {
      int          acc_cyc;
      int          done_cyc;
      logic [63:0] prod;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [2*N-1:0]   p;

   int               cyc    = 0;
   int               n_chk  = 0;
   int               n_pass = 0;
   bit               mon_en = 1'b0;
   exp_t             q[$];
   logic [63:0]      exp_p  = '0;

   mul_seq_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (a),
      .B     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .P     (p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
   endtask

   // Monitor: expected handshake derived from the oldest outstanding operation.
   always @(negedge clk) begin
      logic eb;
      logic ed;
      if (mon_en) begin
         eb = 1'b0;
         ed = 1'b0;
         if (q.size() > 0) begin
            eb = (cyc >= q[0].acc_cyc) && (cyc < q[0].done_cyc);
            ed = (cyc == q[0].done_cyc);
         end
         chk("busy",  64'(busy),  64'(eb));
         chk("ready", 64'(ready), 64'(!eb));
         chk("done",  64'(done),  64'(ed));
         if (ed) begin
            exp_p = q[0].prod;
            void'(q.pop_front());
         end
         chk("P", p, exp_p);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one start pulse; the model decides whether the controller takes it.
   task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
      exp_t e;
      bit   take;
      take  = (q.size() == 0) || (q[$].done_cyc == cyc);
      start = 1'b1;
      a     = x;
      b     = y;
      if (take) begin
         e.acc_cyc  = cyc + 1;
         e.done_cyc = cyc + 1 + int'(N);
`ifdef MUL_SEQ_ZERO_SKIP_EN
         if (q.size() == 0 && (x == '0 || y == '0)) e.done_cyc = cyc + 1;
`endif
         e.prod = {32'd0, x} * {32'd0, y};
         q.push_back(e);
      end
      tick(1);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_ready(input int max);
      int k = 0;
      while (!(q.size() == 0 || q[$].done_cyc == cyc) && k < max) begin
         tick(1);
         k++;
      end
      if (k >= max) begin
         n_chk++;
         $display("FAIL wait_ready timeout cyc=%0d got=%0d expected=<%0d", cyc, k, max);
      end
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (q.size() != 0 && k < max) begin
         tick(1);
         k++;
      end
      if (k >= max) begin
         n_chk++;
         $display("FAIL wait_idle timeout cyc=%0d got=%0d expected=<%0d", cyc, k, max);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      tick(1);
      q.delete();
      exp_p = '0;
      rst   = 1'b0;
   endtask

   function automatic logic [N-1:0] pick();
      int unsigned sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0:       return '0;
         1:       return '1;
         2:       return N'(1);
         3:       return {1'b1, {(N-1){1'b0}}};
         default: return N'($urandom);
      endcase
   endfunction

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      tick(2);
      rst    = 1'b0;
      mon_en = 1'b1;
      chk("reset_ready", 64'(ready), 64'd1);
      chk("reset_P", p, 64'd0);
      tick(2);

      issue(32'd3, 32'd5);
      wait_idle(100);
      chk("basic_P", p, 64'h0000_0000_0000_000F);
      tick(2);

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(100);
      chk("max_P", p, 64'hFFFF_FFFE_0000_0001);
      tick(1);

      issue(32'd7, 32'd9);
      tick(8);
      issue(32'd2, 32'd2);
      wait_idle(100);
      chk("busy_reject_P", p, 64'd63);
      tick(1);

      issue(32'h1234, 32'h5678);
      tick(13);
      do_reset();
      chk("midrst_P", p, 64'd0);
      chk("midrst_ready", 64'(ready), 64'd1);
      tick(2);
      issue(32'd6, 32'd7);
      wait_idle(100);
      chk("after_rst_P", p, 64'd42);
      tick(1);

      issue(32'd10, 32'd10);
      wait_ready(100);
      chk("b2b_first_P", p, 64'd100);
      issue(32'h8000_0000, 32'd2);
      wait_idle(100);
      chk("b2b_second_P", p, 64'h1_0000_0000);
      tick(1);

      issue(32'd0, 32'hDEAD);
      wait_idle(100);
      chk("zero_P", p, 64'd0);
      tick(1);

      repeat (30) begin
         int unsigned gap;
         gap = $urandom_range(0, 3);
         wait_ready(100);
         if (gap > 0) begin
            wait_idle(100);
            tick(int'(gap) - 1);
         end
         issue(pick(), pick());
         if ($urandom_range(0, 3) == 0) begin
            tick(3);
            issue(pick(), pick());
         end
      end

      wait_idle(200);
      tick(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

endmodule
